// File: rtl/bus_2m2s_pkg.sv
// Shared encodings for the two-master/two-slave bus: arbiter states, read-return select, default address map.
package bus_2m2s_pkg;

    typedef enum logic {
        GNT_M0 = 1'b0,
        GNT_M1 = 1'b1
    } gnt_state_e;

    // One-hot per slave so the registered select mirrors {S1_sel, S0_sel} of the read cycle
    typedef enum logic [1:0] {
        RD_NONE = 2'b00,
        RD_S0   = 2'b01,
        RD_S1   = 2'b10
    } rd_sel_e;

    localparam int          AW_DEF       = 8;
    localparam int          DW_DEF       = 32;
    localparam logic [7:0]  S0_BASE_DEF  = 8'h00;
    localparam logic [7:0]  S1_BASE_DEF  = 8'h20;
    localparam logic [7:0]  SLV_MASK_DEF = 8'hE0;

endpackage

// File: rtl/bus_arbiter.sv
// Fixed-priority, non-preemptive two-master grant FSM; grant moves one edge after the request condition.
// No backpressure: a master keeps req high for as long as it wants the bus.
module bus_arbiter
    import bus_2m2s_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic m0_req,
    input  logic m1_req,
    output logic m0_grant,
    output logic m1_grant
);

    gnt_state_e state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= GNT_M0;
            m0_grant <= 1'b1;
            m1_grant <= 1'b0;
        end else begin
            case (state)
                GNT_M0: begin
                    // M0 has priority: M1 only gets the bus when M0 is idle
                    if (!m0_req && m1_req) begin
                        state    <= GNT_M1;
                        m0_grant <= 1'b0;
                        m1_grant <= 1'b1;
                    end
                end
                GNT_M1: begin
                    // Bus parks on M0 whenever M1 lets go, even if M0 is idle
                    if (!m1_req) begin
                        state    <= GNT_M0;
                        m0_grant <= 1'b1;
                        m1_grant <= 1'b0;
                    end
                end
                default: begin
                    state    <= GNT_M0;
                    m0_grant <= 1'b1;
                    m1_grant <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/bus_2m2s.sv
// Two-master/two-slave shared bus: arbitrated mux and decode are combinational, read data returns one cycle later.
// No backpressure: slaves always accept; a non-granted master simply waits for its grant.
module bus_2m2s
    import bus_2m2s_pkg::*;
#(
    parameter int             AW       = AW_DEF,
    parameter int             DW       = DW_DEF,
    parameter logic [AW-1:0]  S0_BASE  = S0_BASE_DEF,
    parameter logic [AW-1:0]  S1_BASE  = S1_BASE_DEF,
    parameter logic [AW-1:0]  SLV_MASK = SLV_MASK_DEF
)(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          M0_req,
    input  logic          M0_wr,
    input  logic [AW-1:0] M0_addr,
    input  logic [DW-1:0] M0_dout,
    output logic          M0_grant,
    input  logic          M1_req,
    input  logic          M1_wr,
    input  logic [AW-1:0] M1_addr,
    input  logic [DW-1:0] M1_dout,
    output logic          M1_grant,
    output logic [DW-1:0] M_din,
    output logic          S0_sel,
    output logic          S1_sel,
    output logic          S_wr,
    output logic [AW-1:0] S_addr,
    output logic [DW-1:0] S_din,
    input  logic [DW-1:0] S0_dout,
    input  logic [DW-1:0] S1_dout
);

    logic    granted_req;
    rd_sel_e rd_sel;

    bus_arbiter u_arbiter (
        .clk      (clk),
        .reset_n  (reset_n),
        .m0_req   (M0_req),
        .m1_req   (M1_req),
        .m0_grant (M0_grant),
        .m1_grant (M1_grant)
    );

    always_comb begin
        granted_req = M0_req;
        S_wr        = M0_wr;
        S_addr      = M0_addr;
        S_din       = M0_dout;
        if (M1_grant) begin
            granted_req = M1_req;
            S_wr        = M1_wr;
            S_addr      = M1_addr;
            S_din       = M1_dout;
        end
    end

    // Unmapped addresses assert no select, so writes vanish and reads return zero
    assign S0_sel = granted_req && ((S_addr & SLV_MASK) == (S0_BASE & SLV_MASK));
    assign S1_sel = granted_req && ((S_addr & SLV_MASK) == (S1_BASE & SLV_MASK));

    // Tracks which slave owes data next cycle, independent of any grant change in between
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_sel <= RD_NONE;
        end else begin
            rd_sel <= rd_sel_e'({S1_sel & ~S_wr, S0_sel & ~S_wr});
        end
    end

    always_comb begin
        M_din = '0;
        case (rd_sel)
            RD_S0:   M_din = S0_dout;
            RD_S1:   M_din = S1_dout;
            default: M_din = '0;
        endcase
    end

endmodule
